// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO divide path.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [1:0]  HILO_WE_BOTH = 2'b11;
  localparam int unsigned DIV_ITER     = 32;

endpackage

// File: rtl/hilo_div_ctrl_div_step.sv
// One combinational restoring-division step on the {rem, quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  always_comb begin
    w_shift = {rem_i, quo_i[WIDTH-1]};
    w_diff  = w_shift - {2'b00, div_i};
    // A clear top bit means the trial subtract did not borrow.
    if (!w_diff[WIDTH+1]) begin
      rem_o = w_diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = w_shift[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Iterative DIV/DIVU sequencer: stalls execute for 32 restoring steps, then
// writes quotient to LO and remainder to HI for one cycle.
module hilo_div_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       hilo_we_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_qneg;
  logic             r_rneg;

  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_accept;
  logic             w_ready;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_sa     = signed_i & opa_i[WIDTH-1];
  assign w_sb     = signed_i & opb_i[WIDTH-1];
  assign w_abs_a  = w_sa ? ('0 - opa_i) : opa_i;
  assign w_abs_b  = w_sb ? ('0 - opb_i) : opb_i;
  assign w_accept = start_i & ~annul_i;

  assign w_quo_fix = r_qneg ? ('0 - r_quo) : r_quo;
  assign w_rem_fix = r_rneg ? ('0 - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (r_rem),
    .quo_i (r_quo),
    .div_i (r_div),
    .rem_o (w_rem_nx),
    .quo_o (w_quo_nx)
  );

  // Annul kills the stall in the same cycle so the flush is not held off.
  assign stall_o   = rst & (((r_state == IDLE) & w_accept) |
                            (((r_state == RUN) | (r_state == FIX)) & ~annul_i));
  assign w_ready   = (r_state == DONE) & ~annul_i;
  assign ready_o   = w_ready;
  assign hilo_we_o = w_ready ? HILO_WE_BOTH : 2'b00;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem  <= '0;
            r_quo  <= w_abs_a;
            r_div  <= w_abs_b;
            r_qneg <= w_sa ^ w_sb;
            r_rneg <= w_sa;
            r_cnt  <= CW'(WIDTH - 1);
            // Divide by zero bypasses the core and the sign fix entirely.
            if (opb_i == '0) begin
              r_hi    <= opa_i;
              r_lo    <= '1;
              r_state <= DONE;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (annul_i) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          if (annul_i) begin
            r_state <= IDLE;
          end else begin
            r_hi    <= w_rem_fix;
            r_lo    <= w_quo_fix;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed and randomised bench for hilo_div_ctrl with a result scoreboard.
module tb_hilo_div_ctrl;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic         annul_i = 1'b0;
  logic [W-1:0] opa_i = '0;
  logic [W-1:0] opb_i = '0;
  logic         stall_o;
  logic         ready_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic [1:0]   hilo_we_o;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } exp_t;

  exp_t scb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opa_i     (opa_i),
    .opb_i     (opb_i),
    .annul_i   (annul_i),
    .stall_o   (stall_o),
    .ready_o   (ready_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .hilo_we_o (hilo_we_o)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    exp_t   e;
    longint la, lb, q, r;
    if (b == '0) begin
      e.lo = '1;
      e.hi = a;
    end else if (sgn) begin
      la   = longint'($signed(a));
      lb   = longint'($signed(b));
      q    = la / lb;
      r    = la % lb;
      e.lo = q[W-1:0];
      e.hi = r[W-1:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input string tag);
    exp_t e;
    int   last;
    last = (b == '0) ? 1 : int'(DIV_ITER) + 2;
    scb.push_back('{lo: elo, hi: ehi});
    @(posedge clk); #1;
    start_i  = 1'b1;
    signed_i = sgn;
    opa_i    = a;
    opb_i    = b;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      chk({tag, " stall"}, W'(stall_o), W'(c < last));
      chk({tag, " ready"}, W'(ready_o), W'(c == last));
      chk({tag, " we"}, W'(hilo_we_o), (c == last) ? W'(2'b11) : '0);
      if (c == last) begin
        if (scb.size() == 0) begin
          chk({tag, " scoreboard"}, '0, '1);
        end else begin
          e = scb.pop_front();
          chk({tag, " lo"}, lo_o, e.lo);
          chk({tag, " hi"}, hi_o, e.hi);
        end
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, " idle stall"}, W'(stall_o), '0);
    chk({tag, " idle we"}, W'(hilo_we_o), '0);
    chk({tag, " lo hold"}, lo_o, elo);
    chk({tag, " hi hold"}, hi_o, ehi);
  endtask

  // Start 100/7 and annul it in cycle k; plo/phi are the HI/LO values expected afterwards.
  task automatic run_annul(input int k, input logic [W-1:0] plo, input logic [W-1:0] phi,
                           input string tag);
    @(posedge clk); #1;
    start_i  = 1'b1;
    signed_i = 1'b0;
    opa_i    = 32'd100;
    opb_i    = 32'd7;
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      chk({tag, " pre stall"}, W'(stall_o), '1 >> (W - 1));
      @(posedge clk); #1;
    end
    annul_i = 1'b1;
    start_i = (k == 0);
    @(negedge clk);
    chk({tag, " annul stall"}, W'(stall_o), '0);
    chk({tag, " annul ready"}, W'(ready_o), '0);
    chk({tag, " annul we"}, W'(hilo_we_o), '0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, " after stall"}, W'(stall_o), '0);
    chk({tag, " after we"}, W'(hilo_we_o), '0);
    chk({tag, " after lo"}, lo_o, plo);
    chk({tag, " after hi"}, hi_o, phi);
  endtask

  initial begin
    exp_t         m;
    logic [W-1:0] ra, rb;
    logic         rs;

    repeat (2) @(negedge clk);
    chk("rst stall", W'(stall_o), '0);
    chk("rst ready", W'(ready_o), '0);
    chk("rst we", W'(hilo_we_o), '0);
    chk("rst hi", hi_o, '0);
    chk("rst lo", lo_o, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "divu100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div-7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, "div_ovf");
    run_div(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, "divu_by0");
    run_div(32'hFFFF_FFFD, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_by0");

    run_annul(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "annul_run");
    run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "divu9_3");
    run_annul(33, 32'd3, 32'd0, "annul_fix");
    run_annul(0, 32'd3, 32'd0, "annul_idle");
    run_annul(34, 32'd14, 32'd2, "annul_done");

    @(posedge clk); #1;
    start_i  = 1'b1;
    signed_i = 1'b0;
    opa_i    = 32'd100;
    opb_i    = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst stall", W'(stall_o), '0);
    chk("midrst ready", W'(ready_o), '0);
    chk("midrst we", W'(hilo_we_o), '0);
    chk("midrst hi", hi_o, '0);
    chk("midrst lo", lo_o, '0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "post_rst");

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) rb = '0;
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rs);
      run_div(ra, rb, rs, m.lo, m.hi, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Iterative divide sequencer for the pipeline's HI/LO path. It accepts a DIV/DIVU issued in the execute stage and runs a 32-step restoring division. While it works it holds the execute stage stalled, then produces quotient (LO) and remainder (HI) with a one-cycle HI/LO write enable. It sits beside the ALU in the execute stage; its stall feeds the hazard logic and its outputs feed the HI/LO register write port.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  divide instruction present in execute. Held high by the pipeline for as long as the instruction is stalled.
- `signed_i`  in  1  1 = DIV, 0 = DIVU. Sampled with `start_i` in IDLE.
- `opa_i`  in  WIDTH  dividend (rs).
- `opb_i`  in  WIDTH  divisor (rt).
- `annul_i`  in  1  flush or exception kill of the execute stage.
- `stall_o`  out  1  stall request to the execute stage.
- `ready_o`  out  1  result valid for this cycle.
- `hi_o`  out  WIDTH  remainder.
- `lo_o`  out  WIDTH  quotient.
- `hilo_we_o`  out  2  HI/LO write enables: bit 1 = HI, bit 0 = LO.

## Operation
- States: IDLE, RUN, FIX, DONE.
- **IDLE**
  - When `start_i & ~annul_i`: capture |opa| and |opb| (absolute values only when `signed_i`), quotient sign = sa^sb, remainder sign = sa, load counter = WIDTH-1.
  - Next state is RUN, or DONE when `opb_i == 0`.
- **RUN**
  - One restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient bit to 1 when the difference is non-negative.
  - The counter decrements; when it reaches 0, next state is FIX.
- **FIX**
  - Conditionally two's-complement negate the quotient and remainder according to the captured signs.
  - Load `hi_o`/`lo_o`; next state is DONE.
- **DONE**
  - `ready_o` = 1 and `hilo_we_o` = 2'b11 for exactly one cycle; next state is IDLE.
  - `start_i` seen in DONE belongs to the finishing instruction and is ignored.
- **Divide by zero:** `lo_o` = all ones, `hi_o` = `opa_i` as sampled. No sign fix is applied.
- **Overflow case:** signed 0x8000_0000 / 0xFFFF_FFFF gives `lo_o` = 0x8000_0000, `hi_o` = 0. This falls out of the unsigned core without a special case.
- **Annul**
  - `annul_i` in RUN or FIX: next state is IDLE, with no `ready_o` and no `hilo_we_o`. `hi_o`/`lo_o` keep their prior values.
  - `annul_i` in DONE suppresses `hilo_we_o` and `ready_o` in that cycle.
  - `annul_i` together with `start_i` in IDLE: no capture.
- `stall_o` = (IDLE & `start_i` & ~`annul_i`) | RUN | FIX. It is combinational and forced to 0 while `rst` is low.
- Width rules:
  - Remainder register is WIDTH+1 bits for the trial subtract.
  - Counter is $clog2(WIDTH) bits.
  - Negation is modulo 2^WIDTH.

## Timing
- Reset (`rst` low, asynchronous, any state including mid-RUN):
  - state = IDLE, counter = 0, internal registers = 0.
  - `hi_o` = 0, `lo_o` = 0, `ready_o` = 0, `hilo_we_o` = 0, `stall_o` = 0.
- Normal divide, with cycle 0 = IDLE cycle with `start_i` high:
  - Cycles 0–33: `stall_o` high (1 capture cycle + 32 RUN cycles + 1 FIX cycle).
  - Cycle 34: DONE, `stall_o` low, `ready_o` high, `hilo_we_o` = 2'b11.
  - Cycle 35: IDLE; a back-to-back divide can be accepted here.
- Divide by zero: cycle 0 stalls, cycle 1 is DONE.
- Annul in cycle k (RUN or FIX): `stall_o` is low from cycle k, since annul is combinationally killed. IDLE from cycle k+1.
- `hi_o`/`lo_o` are registered and remain stable after DONE until the next FIX or divide-by-zero capture.

## Structure
- Shared package `mips_pkg`:
  - state enum type `div_state_t` (IDLE/RUN/FIX/DONE);
  - `HILO_WE_BOTH` = 2'b11;
  - `DIV_ITER` = 32.
- One sub-module, `div_step`: combinational single restoring step. Inputs: rem (WIDTH+1), quo, divisor. Outputs: next rem, next quo. The FSM, counter, sign logic and output registers stay in `hilo_div_ctrl`.

## Test plan
- DIVU 100 / 7, `start_i` held → `stall_o` high cycles 0–33; cycle 34 `lo_o` = 14, `hi_o` = 2, `hilo_we_o` = 2'b11 for one cycle.
- DIV −7 / 2 → `lo_o` = 0xFFFF_FFFD, `hi_o` = 0xFFFF_FFFF at cycle 34.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `lo_o` = 0x8000_0000, `hi_o` = 0, no hang.
- DIVU 5 / 0 → `stall_o` only in cycle 0; cycle 1 `lo_o` = 0xFFFF_FFFF, `hi_o` = 5, `ready_o` = 1.
- Start 100 / 7, assert `annul_i` at cycle 10 → `stall_o` low from cycle 10, no write enable ever. A new DIVU 9 / 3 started at cycle 12 → `lo_o` = 3, `hi_o` = 0 at cycle 46.
- Pull `rst` low at cycle 20 of a divide → all outputs 0 immediately. After release, a fresh DIVU 100 / 7 completes in 35 cycles with the correct result.
